// File: rtl/lcd_bus_if.sv
// Client request/ack handshake plus the HD44780 pin group driven by the arbiter.
// The master modport is the client side; the slave modport is the arbiter.
interface lcd_bus_if #(
  parameter int NUM_CLI = 2,
  parameter int DATA_W  = 8
);
  logic [NUM_CLI-1:0]             req;
  logic [NUM_CLI-1:0]             req_rs;
  logic [NUM_CLI-1:0][DATA_W-1:0] req_data;
  logic [NUM_CLI-1:0]             ack;
  logic                           busy;
  logic                           init_done;
  logic [DATA_W-1:0]              LCD_DataBus;
  logic                           LCD_RS;
  logic                           LCD_RW;
  logic                           LCD_EN;
  logic                           LCD_ON;

  modport master (
    output req, req_rs, req_data,
    input  ack, busy, init_done
  );

  modport slave (
    input  req, req_rs, req_data,
    output ack, busy, init_done,
    output LCD_DataBus, LCD_RS, LCD_RW, LCD_EN, LCD_ON
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Shared HD44780 write bus: power-up init, two-client round-robin byte writes,
// and all setup / EN strobe / hold / execution-wait timing.
module lcd_bus_arbiter #(
  parameter int unsigned SETUP_CYC  = 20,
  parameter int unsigned EN_CYC     = 75,
  parameter int unsigned HOLD_CYC   = 20,
  parameter int unsigned SHORT_WAIT = 2500,
  parameter int unsigned LONG_WAIT  = 82000,
  parameter int unsigned PWRUP_WAIT = 750000
) (
  input  logic     clk,
  input  logic     rst,
  lcd_bus_if.slave bus
);

  typedef enum logic [2:0] {
    PWRUP, INIT, GRANT, SETUP, PULSE, HOLD, WAIT, IDLE
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] phase_len;
  logic        phase_done;
  logic [1:0]  init_idx;
  logic        rr;          // client holding priority at the next arbitration
  logic        win;
  logic        pend_rs;
  logic [7:0]  pend_data;
  logic        long_wait;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Clear display / return home need the long execution time.
  assign long_wait = !bus.LCD_RS && (bus.LCD_DataBus[7:2] == 6'd0) &&
                     (bus.LCD_DataBus != 8'd0);

  always_comb begin
    phase_len = 32'd1;
    unique case (state)
      PWRUP:   phase_len = 32'(PWRUP_WAIT);
      SETUP:   phase_len = 32'(SETUP_CYC);
      PULSE:   phase_len = 32'(EN_CYC);
      HOLD:    phase_len = 32'(HOLD_CYC);
      WAIT:    phase_len = long_wait ? 32'(LONG_WAIT) : 32'(SHORT_WAIT);
      default: phase_len = 32'd1;
    endcase
  end

  assign phase_done = (cnt == phase_len - 32'd1);
  assign win        = bus.req[rr] ? rr : ~rr;
  assign bus.LCD_RW = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= PWRUP;
      cnt             <= 32'd0;
      init_idx        <= 2'd0;
      rr              <= 1'b0;
      pend_rs         <= 1'b0;
      pend_data       <= 8'd0;
      bus.LCD_DataBus <= 8'd0;
      bus.LCD_RS      <= 1'b0;
      bus.LCD_EN      <= 1'b0;
      bus.LCD_ON      <= 1'b0;
      bus.ack         <= 2'b00;
      bus.busy        <= 1'b1;
      bus.init_done   <= 1'b0;
    end else begin
      bus.LCD_ON <= 1'b1;
      bus.ack    <= 2'b00;
      cnt        <= cnt + 32'd1;
      unique case (state)
        PWRUP: if (phase_done) begin
          state <= INIT;
          cnt   <= 32'd0;
        end
        INIT: begin
          bus.LCD_RS      <= 1'b0;
          bus.LCD_DataBus <= init_byte(init_idx);
          state           <= SETUP;
          cnt             <= 32'd0;
        end
        // Ack is visible this cycle; the captured byte reaches the pins next.
        GRANT: begin
          bus.LCD_RS      <= pend_rs;
          bus.LCD_DataBus <= pend_data;
          state           <= SETUP;
          cnt             <= 32'd0;
        end
        SETUP: if (phase_done) begin
          bus.LCD_EN <= 1'b1;
          state      <= PULSE;
          cnt        <= 32'd0;
        end
        PULSE: if (phase_done) begin
          bus.LCD_EN <= 1'b0;
          state      <= HOLD;
          cnt        <= 32'd0;
        end
        HOLD: if (phase_done) begin
          state <= WAIT;
          cnt   <= 32'd0;
        end
        WAIT: if (phase_done) begin
          cnt <= 32'd0;
          if (bus.init_done || init_idx == 2'd3) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.init_done <= 1'b1;
          end else begin
            init_idx <= init_idx + 2'd1;
            state    <= INIT;
          end
        end
        IDLE: begin
          cnt <= 32'd0;
          if (|bus.req) begin
            bus.ack   <= win ? 2'b10 : 2'b01;
            pend_rs   <= bus.req_rs[win];
            pend_data <= bus.req_data[win];
            rr        <= ~win;
            bus.busy  <= 1'b1;
            state     <= GRANT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed + randomized bench for lcd_bus_arbiter: bus-level monitor feeding a
// transaction-level round-robin and timing model.
module tb_lcd_bus_arbiter;
  localparam int SETUP_CYC  = 2;
  localparam int EN_CYC     = 3;
  localparam int HOLD_CYC   = 2;
  localparam int SHORT_WAIT = 5;
  localparam int LONG_WAIT  = 20;
  localparam int PWRUP_WAIT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  lcd_bus_if bus ();

  lcd_bus_arbiter #(
    .SETUP_CYC (SETUP_CYC),
    .EN_CYC    (EN_CYC),
    .HOLD_CYC  (HOLD_CYC),
    .SHORT_WAIT(SHORT_WAIT),
    .LONG_WAIT (LONG_WAIT),
    .PWRUP_WAIT(PWRUP_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct packed { logic rs; logic [7:0] data; } item_t;
  typedef struct { int cli; item_t it; } exp_t;
  typedef struct { int rise; int fall; int setup; logic rs; logic [7:0] data; bit stable; } pulse_t;

  function automatic item_t mk(input logic rs, input logic [7:0] data);
    item_t it;
    it.rs   = rs;
    it.data = data;
    return it;
  endfunction

  function automatic int exp_wait(input item_t it);
    return (!it.rs && it.data[7:2] == 6'd0 && it.data != 8'd0) ? LONG_WAIT : SHORT_WAIT;
  endfunction

  function automatic item_t rnd_item();
    item_t it;
    if ($urandom_range(3) == 0) begin
      it.rs   = 1'b0;
      it.data = 8'($urandom_range(3));
    end else begin
      it.rs   = 1'($urandom_range(1));
      it.data = 8'($urandom);
    end
    return it;
  endfunction

  // ---------------- client drivers ----------------
  item_t cq0[$];
  item_t cq1[$];
  bit    withdraw = 1'b0;

  initial begin
    bus.req      = 2'b00;
    bus.req_rs   = 2'b00;
    bus.req_data = 16'd0;
    forever begin
      @(negedge clk);
      if (rst) bus.req = 2'b00;
      else if (withdraw) begin
        cq0.delete();
        cq1.delete();
        bus.req = 2'b00;
      end else begin
        if (bus.req[0] && bus.ack[0]) begin
          if (cq0.size() > 0) void'(cq0.pop_front());
          bus.req[0] = 1'b0;
        end
        if (!bus.req[0] && cq0.size() > 0) begin
          bus.req[0] = 1'b1; bus.req_rs[0] = cq0[0].rs; bus.req_data[0] = cq0[0].data;
        end
        if (bus.req[1] && bus.ack[1]) begin
          if (cq1.size() > 0) void'(cq1.pop_front());
          bus.req[1] = 1'b0;
        end
        if (!bus.req[1] && cq1.size() > 0) begin
          bus.req[1] = 1'b1; bus.req_rs[1] = cq1[0].rs; bus.req_data[1] = cq1[0].data;
        end
      end
    end
  end

  // ---------------- bus monitor ----------------
  pulse_t pq[$];
  int     ack_t[$];
  int     ack_c[$];
  int     blo[$];
  int     idone_t[$];
  logic       m_pen, m_pbusy, m_pidone;
  logic [8:0] m_pbus;
  int         m_last_chg;
  pulse_t     m_cur;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pen = 1'b0; m_pbusy = 1'b1; m_pidone = 1'b0; m_pbus = 9'd0; m_last_chg = cyc;
      end else begin
        if ({bus.LCD_RS, bus.LCD_DataBus} != m_pbus) m_last_chg = cyc;
        if (bus.LCD_EN && !m_pen) begin
          m_cur.rise = cyc; m_cur.setup = cyc - m_last_chg;
          m_cur.rs = bus.LCD_RS; m_cur.data = bus.LCD_DataBus; m_cur.stable = 1'b1;
        end else if (bus.LCD_EN && {bus.LCD_RS, bus.LCD_DataBus} != {m_cur.rs, m_cur.data})
          m_cur.stable = 1'b0;
        if (!bus.LCD_EN && m_pen) begin
          m_cur.fall = cyc;
          pq.push_back(m_cur);
        end
        if (bus.ack != 2'b00) begin
          chk("ack_onehot", $countones(bus.ack), 1);
          ack_t.push_back(cyc);
          ack_c.push_back(bus.ack[1] ? 1 : 0);
        end
        if (!bus.busy && m_pbusy) blo.push_back(cyc);
        if (bus.init_done && !m_pidone) idone_t.push_back(cyc);
        m_pen = bus.LCD_EN; m_pbusy = bus.busy; m_pidone = bus.init_done;
        m_pbus = {bus.LCD_RS, bus.LCD_DataBus};
      end
    end
  end

  task automatic clr_mon();
    pq.delete(); ack_t.delete(); ack_c.delete(); blo.delete(); idone_t.delete();
  endtask

  // ---------------- reference model state ----------------
  int    last_cli = 1;        // so client 0 is favoured after reset
  item_t model_prev;
  item_t b0[$];
  item_t b1[$];

  task automatic check_init(input int rel, input bit wd);
    item_t tbl [4];
    int n;
    tbl[0] = mk(1'b0, 8'h38); tbl[1] = mk(1'b0, 8'h0C);
    tbl[2] = mk(1'b0, 8'h01); tbl[3] = mk(1'b0, 8'h06);
    n = 0;
    while (!bus.init_done && n < 2000) begin tick(); n++; end
    if (wd) withdraw = 1'b1;
    chk("init_done_seen", bus.init_done, 1);
    chk("init_no_early_ack", ack_t.size(), 0);
    tick();
    withdraw = 1'b0;
    chk("init_busy_low", bus.busy, 0);
    chk("init_pulses", pq.size(), 4);
    if (pq.size() >= 4 && idone_t.size() >= 1 && blo.size() >= 1) begin
      chk("init_first_rise", pq[0].rise - rel, PWRUP_WAIT + 1 + SETUP_CYC);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("init%0d_data", k), pq[k].data, tbl[k].data);
        chk($sformatf("init%0d_rs", k), pq[k].rs, tbl[k].rs);
        chk($sformatf("init%0d_width", k), pq[k].fall - pq[k].rise, EN_CYC);
        chk($sformatf("init%0d_setup", k), pq[k].setup, SETUP_CYC);
        chk($sformatf("init%0d_stable", k), pq[k].stable, 1);
        if (k < 3)
          chk($sformatf("init%0d_gap", k), pq[k+1].rise - pq[k].fall,
              HOLD_CYC + exp_wait(tbl[k]) + 1 + SETUP_CYC);
      end
      chk("init_done_time", idone_t[0] - pq[3].fall, HOLD_CYC + SHORT_WAIT);
      chk("init_busy_fall", blo[0], idone_t[0]);
    end
    model_prev = tbl[3];
    last_cli   = 1;
  endtask

  task automatic run_batch(input string name);
    exp_t ex[$];
    exp_t e;
    int i0, i1, fav, pick, n, total;
    bit has0, has1;
    i0 = 0; i1 = 0;
    while (i0 < b0.size() || i1 < b1.size()) begin
      has0 = (i0 < b0.size()); has1 = (i1 < b1.size());
      fav  = 1 - last_cli;
      pick = (fav == 0) ? (has0 ? 0 : 1) : (has1 ? 1 : 0);
      e.cli = pick;
      e.it  = (pick == 0) ? b0[i0] : b1[i1];
      if (pick == 0) i0++; else i1++;
      ex.push_back(e);
      last_cli = pick;
    end
    total = ex.size();
    clr_mon();
    foreach (b0[k]) cq0.push_back(b0[k]);
    foreach (b1[k]) cq1.push_back(b1[k]);
    n = 0;
    while ((pq.size() < total || blo.size() < total) && n < 100 * total + 100) begin
      tick(); n++;
    end
    chk({name, "_pulses"}, pq.size(), total);
    chk({name, "_acks"}, ack_t.size(), total);
    chk({name, "_busy_falls"}, blo.size(), total);
    if (pq.size() >= total && ack_t.size() >= total && blo.size() >= total) begin
      for (int k = 0; k < total; k++) begin
        chk($sformatf("%s%0d_ack_cli", name, k), ack_c[k], ex[k].cli);
        chk($sformatf("%s%0d_data", name, k), pq[k].data, ex[k].it.data);
        chk($sformatf("%s%0d_rs", name, k), pq[k].rs, ex[k].it.rs);
        chk($sformatf("%s%0d_width", name, k), pq[k].fall - pq[k].rise, EN_CYC);
        chk($sformatf("%s%0d_stable", name, k), pq[k].stable, 1);
        if (ex[k].it != model_prev)
          chk($sformatf("%s%0d_setup", name, k), pq[k].setup, SETUP_CYC);
        else
          chk($sformatf("%s%0d_setup_min", name, k), pq[k].setup >= SETUP_CYC, 1);
        chk($sformatf("%s%0d_ack2en", name, k), pq[k].rise - ack_t[k], 1 + SETUP_CYC);
        chk($sformatf("%s%0d_wait", name, k), blo[k] - pq[k].fall, HOLD_CYC + exp_wait(ex[k].it));
        if (k > 0)
          chk($sformatf("%s%0d_spacing", name, k), ack_t[k] - ack_t[k-1],
              1 + SETUP_CYC + EN_CYC + HOLD_CYC + exp_wait(ex[k-1].it) + 1);
        model_prev = ex[k].it;
      end
    end
    b0.delete();
    b1.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rel, n;
    repeat (3) tick();
    chk("rst_lcd_on", bus.LCD_ON, 0);
    chk("rst_en", bus.LCD_EN, 0);
    chk("rst_rs", bus.LCD_RS, 0);
    chk("rst_rw", bus.LCD_RW, 0);
    chk("rst_data", bus.LCD_DataBus, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 1);
    chk("rst_init_done", bus.init_done, 0);

    // Client 0 requests during init and withdraws the cycle init completes.
    cq0.push_back(mk(1'b1, 8'h41));
    @(negedge clk); #1 rst = 1'b0; rel = cyc;
    chk("lcd_on_pre_edge", bus.LCD_ON, 0);
    tick();
    chk("lcd_on_1clk", bus.LCD_ON, 1);
    check_init(rel, 1'b1);
    repeat (30) tick();
    chk("withdraw_no_ack", ack_t.size(), 0);
    chk("withdraw_no_pulse", pq.size(), 4);
    chk("withdraw_idle", bus.busy, 0);

    b0.push_back(mk(1'b1, 8'h31)); b0.push_back(mk(1'b1, 8'h31));
    b1.push_back(mk(1'b1, 8'h3A)); b1.push_back(mk(1'b1, 8'h3A));
    run_batch("contend");
    b0.push_back(mk(1'b1, 8'h35));
    run_batch("single");
    b1.push_back(mk(1'b0, 8'h02));
    run_batch("home");
    b1.push_back(mk(1'b0, 8'h80));
    run_batch("ddram");

    for (int r = 0; r < 4; r++) begin
      int c0, c1;
      c0 = $urandom_range(4);
      c1 = $urandom_range(4);
      if (c0 + c1 == 0) c0 = 1;
      for (int k = 0; k < c0; k++) b0.push_back(rnd_item());
      for (int k = 0; k < c1; k++) b1.push_back(rnd_item());
      run_batch($sformatf("rnd%0d_", r));
    end

    // Reset while EN is high: async drop, abandoned transfer, full re-init.
    clr_mon();
    cq1.push_back(mk(1'b1, 8'h55));
    n = 0;
    while (!bus.LCD_EN && n < 200) begin tick(); n++; end
    chk("rstmid_en_seen", bus.LCD_EN, 1);
    #1 rst = 1'b1;
    cq0.delete();
    cq1.delete();
    #1;
    chk("rstmid_en", bus.LCD_EN, 0);
    chk("rstmid_lcd_on", bus.LCD_ON, 0);
    chk("rstmid_busy", bus.busy, 1);
    chk("rstmid_init_done", bus.init_done, 0);
    chk("rstmid_ack", bus.ack, 0);
    tick(); tick();
    @(negedge clk); #1 rst = 1'b0; rel = cyc;
    clr_mon();
    check_init(rel, 1'b0);
    repeat (20) tick();
    chk("rstmid_no_replay", ack_t.size(), 0);
    chk("rstmid_no_extra_pulse", pq.size(), 4);

    b0.push_back(rnd_item()); b0.push_back(rnd_item());
    b1.push_back(rnd_item()); b1.push_back(mk(1'b0, 8'h01));
    run_batch("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
